lcd_text_seq: RTL

Command sequencer directly upstream of the LCD dot-matrix controller. After reset it waits for LCD power-up, issues the HD44780 init instructions, then copies a 32-character text buffer (2 lines × 16) from an external synchronous RAM to the display. Each transfer is one single-cycle command pulse to the controller, followed by a fixed settling gap. A `refresh` pulse triggers a redraw.

---
 rtl/lcd_text_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/lcd_text_seq.sv
// Command sequencer for the LCD controller: waits for power-up, issues the
// HD44780 init instructions, then copies a 2x16 text buffer from RAM on request.
module lcd_text_seq #(
    parameter int PWRUP_WAIT = 2000000,
    parameter int CMD_GAP    = 4096,
    parameter int CLR_GAP    = 200000,
    parameter int DLY_W      = 21
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       refresh,
    output logic [4:0] ram_addr,
    input  logic [7:0] ram_data,
    output logic [7:0] lcd_db,
    output logic       lcd_rs_sel,
    output logic       lcd_rwb_sel,
    output logic       lcd_cmmd,
    output logic       lcd_instr,
    output logic       busy,
    output logic       init_done
);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT,
        S_IWAIT,
        S_LADDR,
        S_DATA,
        S_GWAIT,
        S_IDLE
    } state_t;

    localparam logic [DLY_W-1:0] PWRUP_LOAD = DLY_W'(PWRUP_WAIT - 1);
    localparam logic [DLY_W-1:0] CMD_LOAD   = DLY_W'(CMD_GAP - 1);
    localparam logic [DLY_W-1:0] CLR_LOAD   = DLY_W'(CLR_GAP - 1);
    localparam logic [DLY_W-1:0] DLY_ONE    = DLY_W'(1);
    localparam logic [5:0]       LINE2_CHAR = 6'd16;
    localparam logic [5:0]       END_CHAR   = 6'd32;
    localparam logic [1:0]       LAST_INIT  = 2'd3;
    localparam logic [1:0]       CLEAR_IDX  = 2'd2;
    localparam logic [7:0]       DDRAM_L1   = 8'h80;
    localparam logic [7:0]       DDRAM_L2   = 8'hC0;

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        logic [7:0] b;
        unique case (i)
            2'd0:    b = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
            2'd1:    b = 8'h0C;  // display on, cursor off
            2'd2:    b = 8'h01;  // clear display
            default: b = 8'h06;  // increment, no shift
        endcase
        return b;
    endfunction

    state_t           state, state_nx;
    logic [DLY_W-1:0] dly, dly_nx;
    logic [1:0]       idx, idx_nx;
    logic [5:0]       chr, chr_nx;
    logic             line2_sent, line2_sent_nx;
    logic             pend, pend_nx;
    logic             init_done_nx;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_PWRUP;
            dly        <= PWRUP_LOAD;
            idx        <= '0;
            chr        <= '0;
            line2_sent <= 1'b0;
            pend       <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            state      <= state_nx;
            dly        <= dly_nx;
            idx        <= idx_nx;
            chr        <= chr_nx;
            line2_sent <= line2_sent_nx;
            pend       <= pend_nx;
            init_done  <= init_done_nx;
        end
    end

    // The strobe cycle counts as the first gap cycle, so wait states leave
    // at count 1 to keep strobe-to-strobe spacing exactly equal to the gap.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_nx      = state;
        dly_nx        = dly;
        idx_nx        = idx;
        chr_nx        = chr;
        line2_sent_nx = line2_sent;
        pend_nx       = pend | refresh;
        init_done_nx  = init_done;
        lcd_db        = 8'h00;
        lcd_rs_sel    = 1'b0;
        lcd_cmmd      = 1'b0;
        lcd_instr     = 1'b0;

        unique case (state)
            S_PWRUP: begin
                if (dly == '0) state_nx = S_INIT;
                else           dly_nx   = dly - DLY_ONE;
            end
            S_INIT: begin
                lcd_cmmd  = 1'b1;
                lcd_instr = 1'b1;
                lcd_db    = init_byte(idx);
                dly_nx    = (idx == CLEAR_IDX) ? CLR_LOAD : CMD_LOAD;
                state_nx  = S_IWAIT;
            end
            S_IWAIT: begin
                if (dly == DLY_ONE) begin
                    if (idx == LAST_INIT) begin
                        init_done_nx = 1'b1;
                        state_nx     = S_LADDR;
                    end else begin
                        idx_nx   = idx + 2'd1;
                        state_nx = S_INIT;
                    end
                end else begin
                    dly_nx = dly - DLY_ONE;
                end
            end
            S_LADDR: begin
                lcd_cmmd  = 1'b1;
                lcd_instr = 1'b1;
                if (chr == LINE2_CHAR) begin
                    lcd_db        = DDRAM_L2;
                    line2_sent_nx = 1'b1;
                end else begin
                    lcd_db = DDRAM_L1;
                end
                dly_nx   = CMD_LOAD;
                state_nx = S_GWAIT;
            end
            S_DATA: begin
                lcd_cmmd   = 1'b1;
                lcd_rs_sel = 1'b1;
                lcd_db     = ram_data;
                chr_nx     = chr + 6'd1;
                dly_nx     = CMD_LOAD;
                state_nx   = S_GWAIT;
            end
            S_GWAIT: begin
                if (dly == DLY_ONE) begin
                    if (chr == LINE2_CHAR && !line2_sent) state_nx = S_LADDR;
                    else if (chr < END_CHAR)              state_nx = S_DATA;
                    else                                  state_nx = S_IDLE;
                end else begin
                    dly_nx = dly - DLY_ONE;
                end
            end
            S_IDLE: begin
                if (refresh || pend) begin
                    chr_nx        = '0;
                    line2_sent_nx = 1'b0;
                    pend_nx       = 1'b0;
                    state_nx      = S_LADDR;
                end
            end
            default: state_nx = S_PWRUP;
        endcase
    end

    // The address register is the char index itself, so it moves on the edge
    // ending each data strobe and holds through the whole gap for the RAM.
    assign ram_addr    = chr[4:0];
    assign lcd_rwb_sel = 1'b0;
    assign busy        = (state != S_IDLE);

endmodule
